// File: rtl/pipe_pkg.sv
// Shared definitions for the elastic inter-stage pipeline register.
// State encoding, NOP payload and perf counter width.
package pipe_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_e;

  // sll $0,$0,0
  localparam logic [31:0] INSTR_NOP = 32'h0000_0000;

  localparam int PERF_W = 16;

endpackage

// File: rtl/pipe_sat_counter.sv
// Saturating up-counter with synchronous clear; updates on the falling edge
// to match the pipeline stage it instruments.
module pipe_sat_counter #(
  parameter int W = 16
) (
  input  logic         clk_i,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(negedge clk_i) begin
    if (clr_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Elastic pipeline register: main (head) + skid entry, valid/ready both sides,
// flush-to-bubble. Optional perf counters under PIPE_STAGE_PERF_EN.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int               WIDTH  = 32,
  parameter int               PC_W   = 32,
  parameter logic [WIDTH-1:0] BUBBLE = WIDTH'(INSTR_NOP)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  in_data,
  input  logic [PC_W-1:0]   in_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  out_data,
  output logic [PC_W-1:0]   out_pc,
  output logic [1:0]        occupancy
`ifdef PIPE_STAGE_PERF_EN
  ,
  output logic [PERF_W-1:0] stall_cnt,
  output logic [PERF_W-1:0] flush_cnt
`endif
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] main_data_q, main_data_d;
  logic [PC_W-1:0]  main_pc_q, main_pc_d;
  logic [WIDTH-1:0] skid_data_q, skid_data_d;
  logic [PC_W-1:0]  skid_pc_q, skid_pc_d;
  logic             in_ready_q, out_valid_q;
  logic             fire_in, fire_out;

  assign fire_in  = in_valid & in_ready_q;
  assign fire_out = out_valid_q & out_ready;

  always_comb begin
    state_d     = state_q;
    main_data_d = main_data_q;
    main_pc_d   = main_pc_q;
    skid_data_d = skid_data_q;
    skid_pc_d   = skid_pc_q;
    if (flush) begin
      // Any word offered on this edge is dropped; skid is left as-is (never read when EMPTY).
      state_d     = ST_EMPTY;
      main_data_d = BUBBLE;
      main_pc_d   = '0;
    end else begin
      unique case (state_q)
        ST_EMPTY: begin
          if (fire_in) begin
            main_data_d = in_data;
            main_pc_d   = in_pc;
            state_d     = ST_ONE;
          end
        end
        ST_ONE: begin
          if (fire_in && fire_out) begin
            main_data_d = in_data;
            main_pc_d   = in_pc;
          end else if (fire_out) begin
            main_data_d = BUBBLE;
            main_pc_d   = '0;
            state_d     = ST_EMPTY;
          end else if (fire_in) begin
            skid_data_d = in_data;
            skid_pc_d   = in_pc;
            state_d     = ST_TWO;
          end
        end
        ST_TWO: begin
          if (fire_out) begin
            main_data_d = skid_data_q;
            main_pc_d   = skid_pc_q;
            state_d     = ST_ONE;
          end
        end
        default: begin
          state_d     = ST_EMPTY;
          main_data_d = BUBBLE;
          main_pc_d   = '0;
        end
      endcase
    end
  end

  // Handshake flags are registered from next state so no input reaches an output.
  always_ff @(negedge clk) begin
    if (rst) begin
      state_q     <= ST_EMPTY;
      main_data_q <= BUBBLE;
      main_pc_q   <= '0;
      skid_data_q <= '0;
      skid_pc_q   <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      main_data_q <= main_data_d;
      main_pc_q   <= main_pc_d;
      skid_data_q <= skid_data_d;
      skid_pc_q   <= skid_pc_d;
      in_ready_q  <= (state_d != ST_TWO);
      out_valid_q <= (state_d != ST_EMPTY);
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = main_data_q;
  assign out_pc    = main_pc_q;
  assign occupancy = state_q;

`ifdef PIPE_STAGE_PERF_EN
  logic stall_inc, flush_inc;

  assign stall_inc = out_valid_q & ~out_ready;
  assign flush_inc = flush & (state_q != ST_EMPTY);

  pipe_sat_counter #(.W(PERF_W)) u_stall_cnt (
    .clk_i (clk),
    .clr_i (rst),
    .inc_i (stall_inc),
    .cnt_o (stall_cnt)
  );

  pipe_sat_counter #(.W(PERF_W)) u_flush_cnt (
    .clk_i (clk),
    .clr_i (rst),
    .inc_i (flush_inc),
    .cnt_o (flush_cnt)
  );
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: queue-based reference model checked every cycle,
// plus directed literal checks. Perf checks are compiled with PIPE_STAGE_PERF_EN.
module tb_pipe_stage_reg;
  import pipe_pkg::*;

  localparam int W  = 32;
  localparam int PW = 32;

  logic          clk = 1'b0;
  logic          rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [W-1:0]  in_data, out_data;
  logic [PW-1:0] in_pc, out_pc;
  logic [1:0]    occupancy;
`ifdef PIPE_STAGE_PERF_EN
  logic [15:0]   stall_cnt, flush_cnt;
`endif

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  pipe_stage_reg #(.WIDTH(W), .PC_W(PW), .BUBBLE('0)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_pc     (in_pc),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_pc    (out_pc),
    .occupancy (occupancy)
`ifdef PIPE_STAGE_PERF_EN
    ,
    .stall_cnt (stall_cnt),
    .flush_cnt (flush_cnt)
`endif
  );

  typedef struct packed {
    logic [W-1:0]  d;
    logic [PW-1:0] pc;
  } word_t;

  // Reference model: a FIFO of at most two words, updated on the active (falling) edge.
  word_t       mq[$];
  bit          m_ok = 1'b0;
  int unsigned m_stall = 0, m_flush = 0;
  bit          m_fo, m_fi;

  always @(negedge clk) begin
    if (rst) begin
      mq.delete();
      m_ok    = 1'b1;
      m_stall = 0;
      m_flush = 0;
    end else begin
      m_fo = (mq.size() > 0) && out_ready;
      m_fi = in_valid && (mq.size() < 2);
      if ((mq.size() > 0) && !out_ready && (m_stall < 65535)) m_stall++;
      if (flush) begin
        if ((mq.size() > 0) && (m_flush < 65535)) m_flush++;
        mq.delete();
      end else begin
        if (m_fo) void'(mq.pop_front());
        if (m_fi) mq.push_back(word_t'{in_data, in_pc});
      end
    end
  end

  // Compare process: outputs are stable around the rising edge.
  word_t         dlv[$];
  int            max_occ = 0;
  bit            rdy_drop = 1'b0;
  bit            acc_in = 1'b0, acc_out = 1'b0;
  int            n;
  logic [W-1:0]  e_d;
  logic [PW-1:0] e_pc;

  always @(posedge clk) begin
    acc_in  = in_valid & in_ready;
    acc_out = out_valid & out_ready;
    if (m_ok) begin
      n    = mq.size();
      e_d  = (n > 0) ? mq[0].d  : '0;
      e_pc = (n > 0) ? mq[0].pc : '0;
      tests++;
      if (out_valid !== (n > 0) || out_data !== e_d || out_pc !== e_pc ||
          in_ready !== (n < 2) || occupancy !== 2'(n)) begin
        fails++;
        $display("FAIL model t=%0t: got v=%b d=%h pc=%h rdy=%b occ=%0d, want v=%b d=%h pc=%h rdy=%b occ=%0d",
                 $time, out_valid, out_data, out_pc, in_ready, occupancy,
                 (n > 0), e_d, e_pc, (n < 2), n);
      end
`ifdef PIPE_STAGE_PERF_EN
      tests++;
      if (stall_cnt !== 16'(m_stall) || flush_cnt !== 16'(m_flush)) begin
        fails++;
        $display("FAIL perf-model t=%0t: got stall=%0d flush=%0d, want stall=%0d flush=%0d",
                 $time, stall_cnt, flush_cnt, m_stall, m_flush);
      end
`endif
      if (acc_out) dlv.push_back(word_t'{out_data, out_pc});
      if (int'(occupancy) > max_occ) max_occ = int'(occupancy);
      if (!in_ready) rdy_drop = 1'b1;
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Inputs only ever change just after the falling edge.
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic pos();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [W-1:0] d, input logic [PW-1:0] pc);
    in_data  = d;
    in_pc    = pc;
    in_valid = 1'b1;
    for (int k = 0; k < 50; k++) begin
      step();
      if (acc_in) return;
    end
    chk("offer_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
    in_valid = 1'b1; in_data = 32'h2002_0005; in_pc = 32'h0000_0004;

    // Reset with a word on offer
    step(); step();
    pos();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data",  out_data, 32'h0);
    chk("rst_out_pc",    out_pc, 32'h0);
    chk("rst_occ",       32'(occupancy), 32'd0);
    chk("rst_in_ready",  32'(in_ready), 32'd1);
    step();
    rst = 1'b0;
    step();
    in_valid = 1'b0;
    pos();
    chk("first_out_valid", 32'(out_valid), 32'd1);
    chk("first_out_data",  out_data, 32'h2002_0005);
    chk("first_out_pc",    out_pc, 32'h0000_0004);
    chk("first_occ",       32'(occupancy), 32'd1);
    step();
    out_ready = 1'b1;
    step();

    // Streaming at full rate
    dlv.delete(); max_occ = 0; rdy_drop = 1'b0;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      in_data  = 32'h1000_0000 + 32'(i);
      in_pc    = 32'(4 * (i + 1));
      step();
    end
    in_valid = 1'b0;
    repeat (3) step();
    chk("stream_count", 32'(dlv.size()), 32'd8);
    for (int i = 0; i < 8 && i < dlv.size(); i++) begin
      chk("stream_data", dlv[i].d, 32'h1000_0000 + 32'(i));
      chk("stream_pc",   dlv[i].pc, 32'(4 * (i + 1)));
    end
    chk("stream_max_occ", 32'(max_occ), 32'd1);
    chk("stream_rdy_drop", 32'(rdy_drop), 32'd0);

    // Back-pressure into the skid entry
    out_ready = 1'b0;
    dlv.delete();
    offer(32'hAAAA_0001, 32'h8);
    offer(32'hAAAA_0002, 32'hC);
    in_data = 32'hAAAA_0003; in_pc = 32'h10; in_valid = 1'b1;
    step(); step();
    pos();
    chk("bp_occ",       32'(occupancy), 32'd2);
    chk("bp_in_ready",  32'(in_ready), 32'd0);
    chk("bp_out_data",  out_data, 32'hAAAA_0001);
    step();
    out_ready = 1'b1;
    offer(32'hAAAA_0003, 32'h10);
    in_valid = 1'b0;
    repeat (4) step();
    chk("bp_count", 32'(dlv.size()), 32'd3);
    for (int i = 0; i < 3 && i < dlv.size(); i++)
      chk("bp_order", dlv[i].d, 32'hAAAA_0001 + 32'(i));

    // Flush while full, with a word on offer
    out_ready = 1'b0;
    offer(32'hB000_0001, 32'h20);
    offer(32'hB000_0002, 32'h24);
    in_valid = 1'b0;
    step();
    pos();
    chk("fl2_pre_occ", 32'(occupancy), 32'd2);
    step();
    flush = 1'b1; in_valid = 1'b1; in_data = 32'hDEAD_BEEF; in_pc = 32'h100;
    step();
    flush = 1'b0; in_valid = 1'b0;
    pos();
    chk("fl2_out_valid", 32'(out_valid), 32'd0);
    chk("fl2_out_data",  out_data, 32'h0);
    chk("fl2_occ",       32'(occupancy), 32'd0);
    chk("fl2_in_ready",  32'(in_ready), 32'd1);
    step();
    dlv.delete();
    out_ready = 1'b1;
    repeat (3) step();
    chk("fl2_no_leak", 32'(dlv.size()), 32'd0);

    // Flush in ONE drops a word offered while in_ready=1
    out_ready = 1'b0;
    offer(32'hC000_0001, 32'h30);
    in_data = 32'hCAFE_0001; in_pc = 32'h34; flush = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0;
    pos();
    chk("fl1_occ",      32'(occupancy), 32'd0);
    chk("fl1_out_data", out_data, 32'h0);
    step();

    // rst and flush on the same edge in ONE
    offer(32'hC000_0002, 32'h38);
    in_valid = 1'b0;
    step();
    pos();
    chk("rf_pre_occ", 32'(occupancy), 32'd1);
    step();
    rst = 1'b1; flush = 1'b1;
    step();
    rst = 1'b0; flush = 1'b0;
    pos();
    chk("rf_occ",       32'(occupancy), 32'd0);
    chk("rf_out_valid", 32'(out_valid), 32'd0);
    chk("rf_out_pc",    out_pc, 32'h0);
    chk("rf_in_ready",  32'(in_ready), 32'd1);
`ifdef PIPE_STAGE_PERF_EN
    chk("rf_flush_cnt", 32'(flush_cnt), 32'd0);
`endif
    step();

    // Random traffic; the source obeys the hold rule
    for (int c = 0; c < 3000; c++) begin
      if (!in_valid || acc_in) begin
        in_valid = 1'($urandom_range(0, 1));
        in_data  = $urandom;
        in_pc    = $urandom;
      end
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 19) == 0);
      rst       = ($urandom_range(0, 199) == 0);
      step();
    end
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    step();

`ifdef PIPE_STAGE_PERF_EN
    // Stall counter saturation, then flush counting
    rst = 1'b1;
    step();
    rst = 1'b0; out_ready = 1'b0;
    offer(32'hE000_0001, 32'h40);
    in_valid = 1'b0;
    repeat (70000) step();
    pos();
    chk("perf_stall_sat", 32'(stall_cnt), 32'h0000_FFFF);
    step();
    for (int i = 0; i < 3; i++) begin
      offer(32'hF000_0000 + 32'(i), 32'h50);
      in_valid = 1'b0; flush = 1'b1;
      step();
      flush = 1'b0;
    end
    pos();
    chk("perf_flush_cnt", 32'(flush_cnt), 32'd3);
    chk("perf_stall_hold", 32'(stall_cnt), 32'h0000_FFFF);
    step();
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
